// File: rtl/seven_seg_frame_capture.sv
// Reads a multiplexed 4-digit active-low 7-segment bus. The bus is synced and
// debounced, each digit is decoded back to hex, and complete frames are published.
module seven_seg_frame_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_n,
  input  logic        dp_n,
  input  logic [3:0]  an_n,
  output logic [15:0] value,
  output logic [3:0]  dp_out,
  output logic        frame_valid,
  output logic        bad_pattern,
  output logic        bad_anode
);

  typedef enum logic {COLLECT, PUBLISH} state_t;

  state_t            state, state_next;
  logic [11:0]       s1, s2, s3;
  logic [CNT_W-1:0]  cnt;
  logic              strobe;
  logic [3:0]        an_s;
  logic              dp_s;
  logic [6:0]        glyph;
  logic [3:0]        nib;
  logic              legal;
  logic [3:0]        an_low;
  logic              single_digit;
  logic              multi_digit;
  logic [1:0]        idx;
  logic [15:0]       slots;
  logic [3:0]        dpslots;
  logic [3:0]        seen, seen_next;
  logic              cap;
  logic              bad_p_next, bad_a_next;

  // Two-flop synchronizer, plus s3 to detect change of the synced bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
    end else begin
      s1 <= {an_n, dp_n, seg_n};
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (s2 != s3) begin
      cnt <= '0;
    end else if (cnt != CNT_W'(STABLE_CYCLES)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires exactly once per stable run because cnt saturates above this value.
  assign strobe = (s2 == s3) && (cnt == CNT_W'(STABLE_CYCLES - 2));
  assign an_s   = s2[11:8];
  assign dp_s   = s2[7];
  assign glyph  = ~s2[6:0];
  assign an_low = ~an_s;

  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    case (glyph)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (an_low[k]) idx = 2'(k);
    end
    single_digit = (an_low != 4'b0) && ((an_low & (an_low - 4'd1)) == 4'b0);
    multi_digit  = (an_low != 4'b0) && !single_digit;
  end

  // A strobe during PUBLISH lands on top of the cleared seen mask.
  always_comb begin
    seen_next  = (state == PUBLISH) ? 4'b0 : seen;
    cap        = 1'b0;
    bad_p_next = 1'b0;
    bad_a_next = 1'b0;
    state_next = state;
    if (strobe) begin
      if (single_digit) begin
        if (legal) begin
          cap            = 1'b1;
          seen_next[idx] = 1'b1;
        end else begin
          bad_p_next     = 1'b1;
          seen_next[idx] = 1'b0;
        end
      end else if (multi_digit) begin
        bad_a_next = 1'b1;
      end
    end
    case (state)
      COLLECT: if (seen_next == 4'hF) state_next = PUBLISH;
      PUBLISH: state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen        <= '0;
      slots       <= '0;
      dpslots     <= '0;
      value       <= '0;
      dp_out      <= '0;
      frame_valid <= 1'b0;
      bad_pattern <= 1'b0;
      bad_anode   <= 1'b0;
    end else begin
      seen        <= seen_next;
      bad_pattern <= bad_p_next;
      bad_anode   <= bad_a_next;
      frame_valid <= (state == PUBLISH);
      if (cap) begin
        slots[{idx, 2'b00} +: 4] <= nib;
        dpslots[idx]             <= ~dp_s;
      end
      if (state == PUBLISH) begin
        value  <= slots;
        dp_out <= dpslots;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_frame_capture.sv
// Bench for seven_seg_frame_capture: drives digit scans, models expected frames
// and error pulses with their arrival cycles, and compares on the falling edge.
module tb_seven_seg_frame_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic [15:0] value;
  logic [3:0]  dp_out;
  logic        frame_valid;
  logic        bad_pattern;
  logic        bad_anode;

  seven_seg_frame_capture #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n),
    .value       (value),
    .dp_out      (dp_out),
    .frame_valid (frame_valid),
    .bad_pattern (bad_pattern),
    .bad_anode   (bad_anode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];
  int          exp_cyc_q[$];
  int          bp_q[$];
  int          ba_q[$];

  logic [3:0] m_slot[4];
  logic [3:0] m_dp;
  logic [3:0] m_seen;

  logic [6:0] glyph[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Applies one bus value for hold cycles and updates the reference model.
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int hold);
    logic [3:0] lo;
    logic [6:0] g;
    int nz, di, nb;
    lo = ~an;
    g  = ~seg;
    nz = $countones(lo);
    di = 0;
    nb = -1;
    for (int k = 0; k < 4; k++) if (lo[k]) di = k;
    for (int j = 0; j < 16; j++) if (g == glyph[j]) nb = j;
    if (hold >= 4 && nz == 1) begin
      if (nb >= 0) begin
        m_slot[di] = 4'(nb);
        m_dp[di]   = ~dp;
        m_seen[di] = 1'b1;
        if (m_seen == 4'hF) begin
          exp_q.push_back({m_slot[3], m_slot[2], m_slot[1], m_slot[0], m_dp});
          exp_cyc_q.push_back(cyc + 7);
          m_seen = 4'h0;
        end
      end else begin
        m_seen[di] = 1'b0;
        bp_q.push_back(cyc + 6);
      end
    end else if (hold >= 4 && nz > 1) begin
      ba_q.push_back(cyc + 6);
    end
    an_n  = an;
    seg_n = seg;
    dp_n  = dp;
    repeat (hold) @(negedge clk);
  endtask

  task automatic dig(input int i, input int nb, input logic dp, input int hold);
    drive(~(4'b0001 << i), ~glyph[nb], dp, hold);
  endtask

  task automatic idle(input int n);
    drive(4'hF, 7'h7F, 1'b1, n);
  endtask

  task automatic do_reset(input string tag);
    rst   = 1'b1;
    an_n  = 4'hF;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    #1;
    check_eq({tag, "_value"}, 32'(value), 32'h0);
    check_eq({tag, "_dp_out"}, 32'(dp_out), 32'h0);
    check_eq({tag, "_pulses"}, 32'({frame_valid, bad_pattern, bad_anode}), 32'h0);
    m_seen = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every output pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("frame_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          check_eq("frame_data", {12'h0, value, dp_out}, {12'h0, exp_q.pop_front()});
          check_eq("frame_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        end
      end
      if (bad_pattern) begin
        if (bp_q.size() == 0) check_eq("bad_pattern_unexpected", 32'(bp_q.size()), 32'd1);
        else check_eq("bad_pattern_cycle", 32'(cyc), 32'(bp_q.pop_front()));
      end
      if (bad_anode) begin
        if (ba_q.size() == 0) check_eq("bad_anode_unexpected", 32'(ba_q.size()), 32'd1);
        else check_eq("bad_anode_cycle", 32'(cyc), 32'(ba_q.pop_front()));
      end
    end
  end

  initial begin
    rst    = 1'b1;
    an_n   = 4'hF;
    seg_n  = 7'h7F;
    dp_n   = 1'b1;
    m_dp   = 4'h0;
    m_seen = 4'h0;
    for (int k = 0; k < 4; k++) m_slot[k] = 4'h0;
    repeat (3) @(negedge clk);
    do_reset("reset_init");

    // Frame 1A2F, no decimal points.
    drive(4'b0111, 7'h79, 1'b1, 8);
    drive(4'b1011, 7'h08, 1'b1, 8);
    drive(4'b1101, 7'h24, 1'b1, 8);
    drive(4'b1110, 7'h0E, 1'b1, 8);
    idle(10);
    check_eq("value_1a2f", 32'(value), 32'h1A2F);

    // Same frame, decimal point lit on digit 2 only.
    drive(4'b0111, 7'h79, 1'b1, 8);
    drive(4'b1011, 7'h08, 1'b0, 8);
    drive(4'b1101, 7'h24, 1'b1, 8);
    drive(4'b1110, 7'h0E, 1'b1, 8);
    idle(10);
    check_eq("dp_out_0100", 32'(dp_out), 32'h4);
    check_eq("value_hold", 32'(value), 32'h1A2F);

    // A 3-cycle glitch on digit 0 must not count as that digit.
    dig(0, 5, 1'b1, 3);
    idle(8);
    dig(3, 7, 1'b1, 8);
    dig(2, 3, 1'b1, 8);
    dig(1, 12, 1'b0, 8);
    idle(10);
    check_eq("glitch_no_frame", 32'(value), 32'h1A2F);
    dig(0, 9, 1'b1, 8);
    idle(10);
    check_eq("value_73c9", 32'(value), 32'h73C9);

    // Blank glyph on a single digit, then two anodes at once.
    drive(4'b1110, 7'h7F, 1'b1, 8);
    drive(4'b1100, ~glyph[4], 1'b1, 8);
    idle(10);
    check_eq("bad_no_frame", 32'(value), 32'h73C9);

    // Partial frame discarded by reset.
    dig(3, 1, 1'b1, 8);
    dig(2, 2, 1'b1, 8);
    dig(1, 3, 1'b1, 8);
    do_reset("reset_mid");
    dig(0, 4, 1'b1, 8);
    idle(10);
    check_eq("value_after_rst", 32'(value), 32'h0);

    // Continuous random scan; frames every four digits.
    for (int k = 0; k < 12; k++) begin
      dig(3 - (k % 4), $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(6, 10));
    end
    idle(12);

    check_eq("frames_drained", 32'(exp_q.size()), 32'd0);
    check_eq("bad_pattern_drained", 32'(bp_q.size()), 32'd0);
    check_eq("bad_anode_drained", 32'(ba_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
